mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sits directly upstream of the dual-read/single-write 2048x32 data memory in the pipelined CPU.
- Accepts read/write requests from NUM_CLIENTS requesters (e.g. fetch, load/store, debug) using valid/ready handshakes.
- Each cycle it packs up to two reads and one write onto the memory's three ports, with round-robin fairness.
- Returns read data to the originating client one cycle after acceptance.

Parameters:
- ADDR_W, 11, memory word-address width
- DATA_W, 32, data width
- NUM_CLIENTS, 3, number of requesters (2..4 supported)

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  NUM_CLIENTS  per-client request valid
- req_we  input  NUM_CLIENTS  per-client write(1)/read(0)
- req_adrs  input  NUM_CLIENTS*ADDR_W  packed addresses, client c at [c*ADDR_W +: ADDR_W]
- req_wdata  input  NUM_CLIENTS*DATA_W  packed write data
- req_ready  output  NUM_CLIENTS  grant: request accepted this cycle when valid&ready
- rsp_valid  output  NUM_CLIENTS  read data valid for client c
- rsp_rdata  output  NUM_CLIENTS*DATA_W  packed read data
- mem_w_en, mem_w_adrs, mem_data_in  output  1/ADDR_W/DATA_W  memory write port
- mem_r_en1, mem_r_adrs1  output  1/ADDR_W  memory read port 1
- mem_r_en2, mem_r_adrs2  output  1/ADDR_W  memory read port 2
- mem_data_out1, mem_data_out2  input  DATA_W  memory read data (valid 1 cycle after r_en)

Behaviour:
- Grant logic is combinational from req_* and the registered rr_ptr. The memory command outputs are driven combinationally in the same cycle as req_ready.
- Scan order: clients rr_ptr, rr_ptr+1, ... mod NUM_CLIENTS. Each valid client is considered once, in order. A non-granted client does not stop the scan.
  - Write: granted if the write port is still free.
  - Read: granted to port 1 if free, else port 2 if free, else not granted.
- RAW hazard: a read scanned AFTER a granted write to the same address in the same cycle is not granted (req_ready=0). It wins on a later cycle and sees the new data.
- A read scanned BEFORE a same-address write is granted and returns the old data, because the memory reads before it writes.
- rr_ptr update: on any cycle with at least one grant, rr_ptr <= (index of last granted client in scan order + 1) mod NUM_CLIENTS. Otherwise it holds.
- Unused memory ports: enable 0, address/data 0.
- Response pipeline: registers capture {port1_client, port1_vld, port2_client, port2_vld} at acceptance.
  - Next cycle: rsp_valid[c]=1 for the served client, with rsp_rdata[c] = mem_data_out1 or mem_data_out2 according to the port used.
  - Read latency is exactly 1 cycle from the accept edge. There is no backpressure on responses; clients must always accept rsp_valid.
  - Writes generate no response.
  - rsp_rdata for a client not currently valid is 0.
- A client holds req_* stable until it sees valid&ready. The arbiter never grants a client with req_valid=0.
- Reset (synchronous, takes effect at the edge where reset=1):
  - rr_ptr=0, response pipeline cleared, so rsp_valid=0 and rsp_rdata=0 from the next cycle.
  - While reset=1: req_ready=0 and all mem_*_en=0.
  - Reads accepted in the cycle before reset are dropped (no rsp_valid).
  - The memory's own active-low reset is driven from ~reset at top level.
- Out of scope: no address range checking; ADDR_W matches the memory depth.

Test Plan:
- Reset, then client0 writes adrs 5 = 0xDEADBEEF. Next cycle client1 reads adrs 5 -> req_ready[1]=1, mem_r_en1=1 with adrs 5, and one cycle later rsp_valid[1]=1 with rdata 0xDEADBEEF.
- rr_ptr=0, clients 0,1,2 all read (adrs 1,2,3) -> client0 on port1 and client1 on port2 are granted, req_ready=3'b011, rr_ptr->2. Next cycle client2 is granted on port1. Responses route correctly: client0 gets mem[1], client1 gets mem[2], client2 gets mem[3].
- Clients 0 and 2 write simultaneously with rr_ptr=0 -> only client0 is granted. Client2 is granted next cycle with rr_ptr=1; client2 holding req_* stable confirms its data lands.
- mem[7]=0x11. Client0 writes 7=0x22 while client1 reads 7:
  - with rr_ptr=0 -> read deferred; next cycle the read returns 0x22.
  - with rr_ptr=1 -> both granted and the read returns 0x11.
- Client0 read accepted, reset asserted on the next cycle -> rsp_valid stays 0, req_ready=0 and mem enables are 0 during reset, rr_ptr=0 afterwards.
- Continuous reads from all 3 clients for 30 cycles -> each client receives exactly 20 grants (fairness). No cycle has more than 2 read enables or more than 1 write enable.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Client request/response and memory command bundle for mem_port_arbiter.
// Handshake: a request transfers on a rising edge where req_valid[c] && req_ready[c]; the client holds req_* stable until then.
interface mem_port_arbiter_if #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 32,
  parameter int NUM_CLIENTS = 3
);
  logic [NUM_CLIENTS-1:0]        req_valid;
  logic [NUM_CLIENTS-1:0]        req_we;
  logic [NUM_CLIENTS*ADDR_W-1:0] req_adrs;
  logic [NUM_CLIENTS*DATA_W-1:0] req_wdata;
  logic [NUM_CLIENTS-1:0]        req_ready;
  logic [NUM_CLIENTS-1:0]        rsp_valid;
  logic [NUM_CLIENTS*DATA_W-1:0] rsp_rdata;
  logic                          mem_w_en;
  logic [ADDR_W-1:0]             mem_w_adrs;
  logic [DATA_W-1:0]             mem_data_in;
  logic                          mem_r_en1;
  logic [ADDR_W-1:0]             mem_r_adrs1;
  logic                          mem_r_en2;
  logic [ADDR_W-1:0]             mem_r_adrs2;
  logic [DATA_W-1:0]             mem_data_out1;
  logic [DATA_W-1:0]             mem_data_out2;

  modport slave (
    input  req_valid, req_we, req_adrs, req_wdata, mem_data_out1, mem_data_out2,
    output req_ready, rsp_valid, rsp_rdata, mem_w_en, mem_w_adrs, mem_data_in,
           mem_r_en1, mem_r_adrs1, mem_r_en2, mem_r_adrs2
  );

  modport master (
    output req_valid, req_we, req_adrs, req_wdata, mem_data_out1, mem_data_out2,
    input  req_ready, rsp_valid, rsp_rdata, mem_w_en, mem_w_adrs, mem_data_in,
           mem_r_en1, mem_r_adrs1, mem_r_en2, mem_r_adrs2
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter packing up to two reads and one write per cycle onto a
// dual-read/single-write memory, with one-cycle read responses routed back.
module mem_port_arbiter #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 32,
  parameter int NUM_CLIENTS = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  mem_port_arbiter_if.slave              bus,
  output logic [$clog2(NUM_CLIENTS)-1:0] rr_ptr
);
  localparam int PTR_W = $clog2(NUM_CLIENTS);
  typedef logic [PTR_W-1:0] ptr_t;

  logic [NUM_CLIENTS-1:0]        ready;
  logic                          w_en, r_en1, r_en2;
  logic [ADDR_W-1:0]             w_adrs, r_adrs1, r_adrs2;
  logic [DATA_W-1:0]             w_data;
  ptr_t                          p1_client, p2_client, nxt_ptr;
  ptr_t                          p1_client_q, p2_client_q;
  logic                          p1_vld_q, p2_vld_q;
  logic [NUM_CLIENTS-1:0]        rsp_valid;
  logic [NUM_CLIENTS*DATA_W-1:0] rsp_rdata;

  always_comb begin
    int idx;
    logic [ADDR_W-1:0] adrs;
    idx       = 0;
    adrs      = '0;
    ready     = '0;
    w_en      = 1'b0;
    w_adrs    = '0;
    w_data    = '0;
    r_en1     = 1'b0;
    r_adrs1   = '0;
    r_en2     = 1'b0;
    r_adrs2   = '0;
    p1_client = '0;
    p2_client = '0;
    nxt_ptr   = rr_ptr;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      idx  = (int'(rr_ptr) + k) % NUM_CLIENTS;
      adrs = bus.req_adrs[idx*ADDR_W +: ADDR_W];
      if (!reset && bus.req_valid[idx]) begin
        if (bus.req_we[idx]) begin
          if (!w_en) begin
            w_en       = 1'b1;
            w_adrs     = adrs;
            w_data     = bus.req_wdata[idx*DATA_W +: DATA_W];
            ready[idx] = 1'b1;
            nxt_ptr    = ptr_t'((idx + 1) % NUM_CLIENTS);
          end
        // A read behind an already-granted write to the same word waits, so it sees the new data.
        end else if (!(w_en && (w_adrs == adrs))) begin
          if (!r_en1) begin
            r_en1      = 1'b1;
            r_adrs1    = adrs;
            p1_client  = ptr_t'(idx);
            ready[idx] = 1'b1;
            nxt_ptr    = ptr_t'((idx + 1) % NUM_CLIENTS);
          end else if (!r_en2) begin
            r_en2      = 1'b1;
            r_adrs2    = adrs;
            p2_client  = ptr_t'(idx);
            ready[idx] = 1'b1;
            nxt_ptr    = ptr_t'((idx + 1) % NUM_CLIENTS);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      p1_vld_q    <= 1'b0;
      p2_vld_q    <= 1'b0;
      p1_client_q <= '0;
      p2_client_q <= '0;
    end else begin
      rr_ptr      <= nxt_ptr;
      p1_vld_q    <= r_en1;
      p2_vld_q    <= r_en2;
      p1_client_q <= p1_client;
      p2_client_q <= p2_client;
    end
  end

  // Responses are masked during reset so a read accepted just before reset is dropped.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int c = 0; c < NUM_CLIENTS; c++) begin
      if (!reset) begin
        if (p1_vld_q && (p1_client_q == ptr_t'(c))) begin
          rsp_valid[c]                  = 1'b1;
          rsp_rdata[c*DATA_W +: DATA_W] = bus.mem_data_out1;
        end else if (p2_vld_q && (p2_client_q == ptr_t'(c))) begin
          rsp_valid[c]                  = 1'b1;
          rsp_rdata[c*DATA_W +: DATA_W] = bus.mem_data_out2;
        end
      end
    end
  end

  assign bus.req_ready   = ready;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_rdata   = rsp_rdata;
  assign bus.mem_w_en    = w_en;
  assign bus.mem_w_adrs  = w_adrs;
  assign bus.mem_data_in = w_data;
  assign bus.mem_r_en1   = r_en1;
  assign bus.mem_r_adrs1 = r_adrs1;
  assign bus.mem_r_en2   = r_en2;
  assign bus.mem_r_adrs2 = r_adrs2;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a read-before-write memory model
// and a response scoreboard.
module tb_mem_port_arbiter;
  localparam int ADDR_W      = 11;
  localparam int DATA_W      = 32;
  localparam int NUM_CLIENTS = 3;

  logic       clk;
  logic       reset;
  logic [1:0] dut_ptr;
  int         checks   = 0;
  int         failures = 0;
  logic [33:0] exp_q[$];
  logic [DATA_W-1:0] mem [2048];

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CLIENTS(NUM_CLIENTS)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CLIENTS(NUM_CLIENTS)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .rr_ptr (dut_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: reads sample the old contents on the same edge as a write
  always @(posedge clk) begin
    if (bus.mem_w_en) mem[bus.mem_w_adrs] <= bus.mem_data_in;
    if (bus.mem_r_en1) bus.mem_data_out1 <= mem[bus.mem_r_adrs1];
    if (bus.mem_r_en2) bus.mem_data_out2 <= mem[bus.mem_r_adrs2];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_req(input int c, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    bus.req_valid[c]                  = 1'b1;
    bus.req_we[c]                     = we;
    bus.req_adrs[c*ADDR_W +: ADDR_W]  = a;
    bus.req_wdata[c*DATA_W +: DATA_W] = d;
  endtask

  task automatic drop_req(input int c);
    bus.req_valid[c] = 1'b0;
  endtask

  task automatic push_rsp(input int c, input logic [DATA_W-1:0] d);
    logic [1:0] cc;
    cc = c[1:0];
    exp_q.push_back({cc, d});
  endtask

  // scoreboard: every expectation pushed in an accept cycle is due in the next cycle
  task automatic check_rsp();
    logic [33:0]            e;
    logic [NUM_CLIENTS-1:0] exp_valid;
    logic [DATA_W-1:0]      exp_data [NUM_CLIENTS];
    exp_valid = '0;
    for (int c = 0; c < NUM_CLIENTS; c++) exp_data[c] = '0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      exp_valid[e[33:32]] = 1'b1;
      exp_data[e[33:32]]  = e[31:0];
    end
    check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_valid));
    for (int c = 0; c < NUM_CLIENTS; c++)
      check($sformatf("rsp_rdata%0d", c), 64'(bus.rsp_rdata[c*DATA_W +: DATA_W]), 64'(exp_data[c]));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_rsp();
  endtask

  task automatic check_ptr(input string tag, input logic [1:0] p);
    check(tag, 64'(dut_ptr), 64'(p));
  endtask

  task automatic expect_cmd(input string tag, input logic [2:0] rdy,
                            input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                            input logic r1, input logic [ADDR_W-1:0] a1,
                            input logic r2, input logic [ADDR_W-1:0] a2);
    #1;
    check({tag, ".ready"}, 64'(bus.req_ready), 64'(rdy));
    check({tag, ".w_en"}, 64'(bus.mem_w_en), 64'(we));
    check({tag, ".w_adrs"}, 64'(bus.mem_w_adrs), 64'(wa));
    check({tag, ".w_data"}, 64'(bus.mem_data_in), 64'(wd));
    check({tag, ".r_en1"}, 64'(bus.mem_r_en1), 64'(r1));
    check({tag, ".r_adrs1"}, 64'(bus.mem_r_adrs1), 64'(a1));
    check({tag, ".r_en2"}, 64'(bus.mem_r_en2), 64'(r2));
    check({tag, ".r_adrs2"}, 64'(bus.mem_r_adrs2), 64'(a2));
  endtask

  initial begin
    int exp_ptr;
    int gc [NUM_CLIENTS];
    logic [2:0] exp_rdy;
    logic [DATA_W-1:0] rd_data [NUM_CLIENTS];
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_adrs  = '0;
    bus.req_wdata = '0;

    // reset: requests are ignored and memory idle
    @(negedge clk);
    set_req(0, 1'b0, 11'd9, 32'h0);
    expect_cmd("in_reset", 3'b000, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check_ptr("reset_ptr", 2'd0);
    reset = 1'b0;
    drop_req(0);

    // write then read back through another client
    set_req(0, 1'b1, 11'd5, 32'hDEADBEEF);
    expect_cmd("wr5", 3'b001, 1, 11'd5, 32'hDEADBEEF, 0, 0, 0, 0);
    tick();
    check_ptr("ptr_wr5", 2'd1);
    drop_req(0);
    set_req(1, 1'b0, 11'd5, 32'h0);
    expect_cmd("rd5", 3'b010, 0, 0, 0, 1, 11'd5, 0, 0);
    push_rsp(1, 32'hDEADBEEF);
    tick();
    check_ptr("ptr_rd5", 2'd2);
    drop_req(1);

    // fill words 3, 1, 2, 7
    set_req(2, 1'b1, 11'd3, 32'h333);
    expect_cmd("wr3", 3'b100, 1, 11'd3, 32'h333, 0, 0, 0, 0);
    tick(); drop_req(2);
    set_req(0, 1'b1, 11'd1, 32'h111);
    expect_cmd("wr1", 3'b001, 1, 11'd1, 32'h111, 0, 0, 0, 0);
    tick(); drop_req(0);
    set_req(1, 1'b1, 11'd2, 32'h222);
    expect_cmd("wr2", 3'b010, 1, 11'd2, 32'h222, 0, 0, 0, 0);
    tick(); drop_req(1);
    set_req(2, 1'b1, 11'd7, 32'h11);
    expect_cmd("wr7", 3'b100, 1, 11'd7, 32'h11, 0, 0, 0, 0);
    tick(); drop_req(2);
    check_ptr("ptr_fill", 2'd0);

    // three simultaneous reads: two ports, third waits one cycle
    set_req(0, 1'b0, 11'd1, 32'h0);
    set_req(1, 1'b0, 11'd2, 32'h0);
    set_req(2, 1'b0, 11'd3, 32'h0);
    expect_cmd("rd3way", 3'b011, 0, 0, 0, 1, 11'd1, 1, 11'd2);
    push_rsp(0, 32'h111);
    push_rsp(1, 32'h222);
    tick();
    check_ptr("ptr_rd3way", 2'd2);
    drop_req(0); drop_req(1);
    expect_cmd("rd3way_c2", 3'b100, 0, 0, 0, 1, 11'd3, 0, 0);
    push_rsp(2, 32'h333);
    tick();
    check_ptr("ptr_rd3way_c2", 2'd0);
    drop_req(2);

    // two writers compete for the single write port
    set_req(0, 1'b1, 11'd20, 32'hA0);
    set_req(2, 1'b1, 11'd21, 32'hC2);
    expect_cmd("ww", 3'b001, 1, 11'd20, 32'hA0, 0, 0, 0, 0);
    tick();
    check_ptr("ptr_ww", 2'd1);
    drop_req(0);
    expect_cmd("ww_c2", 3'b100, 1, 11'd21, 32'hC2, 0, 0, 0, 0);
    tick();
    check_ptr("ptr_ww_c2", 2'd0);
    drop_req(2);
    set_req(0, 1'b0, 11'd20, 32'h0);
    set_req(1, 1'b0, 11'd21, 32'h0);
    expect_cmd("rdback", 3'b011, 0, 0, 0, 1, 11'd20, 1, 11'd21);
    push_rsp(0, 32'hA0);
    push_rsp(1, 32'hC2);
    tick();
    check_ptr("ptr_rdback", 2'd2);
    drop_req(0); drop_req(1);

    // bring rr_ptr back to 0
    set_req(2, 1'b0, 11'd3, 32'h0);
    expect_cmd("rd3", 3'b100, 0, 0, 0, 1, 11'd3, 0, 0);
    push_rsp(2, 32'h333);
    tick();
    check_ptr("ptr_rd3", 2'd0);
    drop_req(2);

    // same-address write scanned first: read deferred, then sees new data
    set_req(0, 1'b1, 11'd7, 32'h22);
    set_req(1, 1'b0, 11'd7, 32'h0);
    expect_cmd("raw_defer", 3'b001, 1, 11'd7, 32'h22, 0, 0, 0, 0);
    tick();
    check_ptr("ptr_raw_defer", 2'd1);
    drop_req(0);
    expect_cmd("raw_retry", 3'b010, 0, 0, 0, 1, 11'd7, 0, 0);
    push_rsp(1, 32'h22);
    tick();
    check_ptr("ptr_raw_retry", 2'd2);
    drop_req(1);

    // restore mem[7]=0x11, move rr_ptr to 1
    set_req(2, 1'b1, 11'd7, 32'h11);
    expect_cmd("wr7b", 3'b100, 1, 11'd7, 32'h11, 0, 0, 0, 0);
    tick(); drop_req(2);
    set_req(0, 1'b0, 11'd1, 32'h0);
    expect_cmd("rd1", 3'b001, 0, 0, 0, 1, 11'd1, 0, 0);
    push_rsp(0, 32'h111);
    tick();
    check_ptr("ptr_rd1", 2'd1);
    drop_req(0);

    // read scanned before the same-address write: both granted, old data
    set_req(0, 1'b1, 11'd7, 32'h22);
    set_req(1, 1'b0, 11'd7, 32'h0);
    expect_cmd("raw_before", 3'b011, 1, 11'd7, 32'h22, 1, 11'd7, 0, 0);
    push_rsp(1, 32'h11);
    tick();
    check_ptr("ptr_raw_before", 2'd1);
    drop_req(0); drop_req(1);

    // read accepted, then reset next cycle: response dropped
    set_req(0, 1'b0, 11'd1, 32'h0);
    expect_cmd("pre_rst", 3'b001, 0, 0, 0, 1, 11'd1, 0, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_rsp();
    expect_cmd("during_rst", 3'b000, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check_ptr("ptr_after_rst", 2'd0);
    reset = 1'b0;
    drop_req(0);
    tick();

    // fairness: all three read continuously for 30 cycles
    rd_data[0] = 32'h111;
    rd_data[1] = 32'h222;
    rd_data[2] = 32'h333;
    exp_ptr = 0;
    for (int c = 0; c < NUM_CLIENTS; c++) gc[c] = 0;
    set_req(0, 1'b0, 11'd1, 32'h0);
    set_req(1, 1'b0, 11'd2, 32'h0);
    set_req(2, 1'b0, 11'd3, 32'h0);
    for (int cyc = 0; cyc < 30; cyc++) begin
      #1;
      exp_rdy = '0;
      exp_rdy[exp_ptr] = 1'b1;
      exp_rdy[(exp_ptr + 1) % 3] = 1'b1;
      check("fair.ready", 64'(bus.req_ready), 64'(exp_rdy));
      check("fair.r_ens", 64'({bus.mem_r_en1, bus.mem_r_en2}), 64'(2'b11));
      check("fair.w_en", 64'(bus.mem_w_en), 64'(1'b0));
      for (int c = 0; c < NUM_CLIENTS; c++) begin
        if (exp_rdy[c]) push_rsp(c, rd_data[c]);
        gc[c] += int'(bus.req_ready[c]);
      end
      exp_ptr = (exp_ptr + 2) % 3;
      tick();
    end
    for (int c = 0; c < NUM_CLIENTS; c++)
      check($sformatf("fair.grants%0d", c), 64'(gc[c]), 64'(20));
    check_ptr("ptr_fair", 2'd0);
    bus.req_valid = '0;
    tick();
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
